// File: rtl/csr_unit.sv
// -----------------------------------------------------------------------------
// csr_unit
//
// Machine-mode CSR unit placed beside the execute/writeback stage. It provides
// the Zicsr read-modify-write operations (RW/RS/RC), the free-running 64-bit
// mcycle/minstret counters, trap entry and mret sequencing of mstatus, the
// interrupt pending/enable logic with a prioritised request, and detection of
// illegal CSR accesses. The trap vector and the return PC go back to fetch.
//
// Only XLEN=32 is supported; the 64-bit counters are seen as low/high halves.
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous reset, active low
//   csr_en_i       CSR instruction valid this cycle
//   csr_op_i       00 none, 01 RW, 10 RS, 11 RC
//   csr_idx_i      CSR address
//   csr_wdata_i    rs1 value or zimm
//   csr_rdata_o    old CSR value (combinational, 0 when idle or unimplemented)
//   csr_illegal_o  unimplemented address, or write to a read-only CSR
//   instr_ret_i    one instruction retired this cycle
//   trap_i         take a trap this cycle
//   trap_cause_i   mcause value (bit31 = interrupt)
//   trap_pc_i      PC to save in mepc
//   trap_val_i     mtval value
//   mret_i         mret retiring
//   irq_ext_i      external interrupt line (level)
//   irq_tmr_i      timer interrupt line (level)
//   irq_sw_i       software interrupt line (level)
//   irq_req_o      an enabled interrupt is pending and should be taken
//   irq_cause_o    mcause for the pending interrupt, 0 when none
//   trap_vec_o     trap target PC derived from mtvec and trap_cause_i
//   mepc_o         return PC for mret
// -----------------------------------------------------------------------------
module csr_unit #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            csr_en_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_idx_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            instr_ret_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  input  logic            irq_ext_i,
  input  logic            irq_tmr_i,
  input  logic            irq_sw_i,
  output logic            irq_req_o,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [XLEN-1:0] MISA_VAL = 32'h4000_1104;  // RV32IMC

  // mtvec.MODE bit0 only survives when vectored mode is built in; bit1 never.
  localparam logic [XLEN-1:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD
                                                       : 32'hFFFF_FFFC;

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic              mstatus_mie;
  logic              mstatus_mpie;
  logic [2:0]        mie_bits;      // {MEIE, MTIE, MSIE}
  logic [2:0]        mip_bits;      // {MEIP, MTIP, MSIP}, irq lines delayed 1
  logic [XLEN-1:0]   mtvec_q;
  logic [XLEN-1:0]   mscratch_q;
  logic [XLEN-1:0]   mepc_q;
  logic [XLEN-1:0]   mcause_q;
  logic [XLEN-1:0]   mtval_q;
  logic [2*XLEN-1:0] mcycle_q;
  logic [2*XLEN-1:0] minstret_q;

  // ---------------------------------------------------------------------------
  // Address decode and read mux
  // ---------------------------------------------------------------------------
  csr_op_e         op;
  logic            addr_ok;
  logic            addr_ro;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] mie_val;
  logic [XLEN-1:0] mip_val;

  assign op          = csr_op_e'(csr_op_i);
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mie_val     = {20'b0, mie_bits[2], 3'b0, mie_bits[1], 3'b0, mie_bits[0], 3'b0};
  assign mip_val     = {20'b0, mip_bits[2], 3'b0, mip_bits[1], 3'b0, mip_bits[0], 3'b0};

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the case statement can leave it unassigned and infer
  // a latch.
  always_comb begin
    addr_ok = 1'b1;
    addr_ro = 1'b0;
    old_val = '0;
    case (csr_idx_i)
      ADDR_MSTATUS:   old_val = mstatus_val;
      ADDR_MISA: begin
        old_val = MISA_VAL;
        addr_ro = 1'b1;
      end
      ADDR_MIE:       old_val = mie_val;
      ADDR_MTVEC:     old_val = mtvec_q;
      ADDR_MSCRATCH:  old_val = mscratch_q;
      ADDR_MEPC:      old_val = mepc_q;
      ADDR_MCAUSE:    old_val = mcause_q;
      ADDR_MTVAL:     old_val = mtval_q;
      ADDR_MIP:       old_val = mip_val;      // writable, but no bit takes it
      ADDR_MCYCLE:    old_val = mcycle_q[XLEN-1:0];
      ADDR_MCYCLEH:   old_val = mcycle_q[2*XLEN-1:XLEN];
      ADDR_MINSTRET:  old_val = minstret_q[XLEN-1:0];
      ADDR_MINSTRETH: old_val = minstret_q[2*XLEN-1:XLEN];
      ADDR_MHARTID:   addr_ro = 1'b1;         // hart 0
      default:        addr_ok = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write request qualification
  // ---------------------------------------------------------------------------
  // RS/RC with a zero operand are pure reads (csrr idiom), so they never
  // write and never fault, even on read-only registers.
  logic            wr_try;
  logic            wr_en;
  logic [XLEN-1:0] new_val;

  assign wr_try = csr_en_i &&
                  ((op == OP_RW) ||
                   (((op == OP_RS) || (op == OP_RC)) && (csr_wdata_i != '0)));
  assign wr_en  = wr_try && addr_ok && !addr_ro;

  assign csr_rdata_o   = (csr_en_i && addr_ok) ? old_val : '0;
  assign csr_illegal_o = csr_en_i && (!addr_ok || (wr_try && addr_ro));

  always_comb begin
    new_val = csr_wdata_i;
    case (op)
      OP_RS:   new_val = old_val | csr_wdata_i;
      OP_RC:   new_val = old_val & ~csr_wdata_i;
      default: new_val = csr_wdata_i;
    endcase
  end

  // Trap entry and mret own mstatus/mepc/mcause/mtval in their cycle; a CSR
  // write to any of those in the same cycle is dropped.
  logic hw_owns;
  logic we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause, we_mtval;
  logic we_mcycle, we_mcycleh, we_minstret, we_minstreth;

  assign hw_owns      = trap_i | mret_i;
  assign we_mstatus   = wr_en && (csr_idx_i == ADDR_MSTATUS) && !hw_owns;
  assign we_mie       = wr_en && (csr_idx_i == ADDR_MIE);
  assign we_mtvec     = wr_en && (csr_idx_i == ADDR_MTVEC);
  assign we_mscratch  = wr_en && (csr_idx_i == ADDR_MSCRATCH);
  assign we_mepc      = wr_en && (csr_idx_i == ADDR_MEPC)   && !hw_owns;
  assign we_mcause    = wr_en && (csr_idx_i == ADDR_MCAUSE) && !hw_owns;
  assign we_mtval     = wr_en && (csr_idx_i == ADDR_MTVAL)  && !hw_owns;
  assign we_mcycle    = wr_en && (csr_idx_i == ADDR_MCYCLE);
  assign we_mcycleh   = wr_en && (csr_idx_i == ADDR_MCYCLEH);
  assign we_minstret  = wr_en && (csr_idx_i == ADDR_MINSTRET);
  assign we_minstreth = wr_en && (csr_idx_i == ADDR_MINSTRETH);

  // ---------------------------------------------------------------------------
  // mstatus: trap entry > mret > software write
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_i) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (we_mstatus) begin
      mstatus_mie  <= new_val[3];
      mstatus_mpie <= new_val[7];
    end
  end

  // ---------------------------------------------------------------------------
  // Trap bookkeeping registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_i) begin
      mepc_q   <= trap_pc_i & ~32'h1;
      mcause_q <= trap_cause_i;
      mtval_q  <= trap_val_i;
    end else begin
      if (we_mepc)   mepc_q   <= new_val & ~32'h1;
      if (we_mcause) mcause_q <= new_val;
      if (we_mtval)  mtval_q  <= new_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Plain software registers and the interrupt pending sampler
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mie_bits   <= '0;
      mip_bits   <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
    end else begin
      mip_bits <= {irq_ext_i, irq_tmr_i, irq_sw_i};
      if (we_mie)      mie_bits   <= {new_val[11], new_val[7], new_val[3]};
      if (we_mtvec)    mtvec_q    <= new_val & MTVEC_MASK;
      if (we_mscratch) mscratch_q <= new_val;
    end
  end

  // ---------------------------------------------------------------------------
  // 64-bit counters. A write to either half replaces the increment for the
  // whole counter in that cycle; the other half simply holds.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mcycle_q <= '0;
    end else if (we_mcycle || we_mcycleh) begin
      if (we_mcycle)  mcycle_q[XLEN-1:0]      <= new_val;
      if (we_mcycleh) mcycle_q[2*XLEN-1:XLEN] <= new_val;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      minstret_q <= '0;
    end else if (we_minstret || we_minstreth) begin
      if (we_minstret)  minstret_q[XLEN-1:0]      <= new_val;
      if (we_minstreth) minstret_q[2*XLEN-1:XLEN] <= new_val;
    end else if (instr_ret_i) begin
      minstret_q <= minstret_q + 64'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt request: MEI > MSI > MTI. Gated by rst_ni so nothing is
  // requested while the core is held in reset.
  // ---------------------------------------------------------------------------
  logic [2:0] pend;
  logic [3:0] irq_code;

  assign pend      = mip_bits & mie_bits;
  assign irq_req_o = rst_ni && mstatus_mie && (pend != 3'b000);

  always_comb begin
    irq_code = 4'd0;
    if (pend[2])      irq_code = 4'd11;
    else if (pend[0]) irq_code = 4'd3;
    else if (pend[1]) irq_code = 4'd7;
  end

  assign irq_cause_o = irq_req_o ? {1'b1, 27'b0, irq_code} : '0;

  // ---------------------------------------------------------------------------
  // Trap target and return PC
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] vec_base;

  assign vec_base   = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_vec_o = (mtvec_q[0] && trap_cause_i[XLEN-1])
                    ? vec_base + {25'b0, trap_cause_i[4:0], 2'b00}
                    : vec_base;
  assign mepc_o     = rst_ni ? mepc_q : '0;

endmodule

// File: tb/tb_csr_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_unit
//
// Directed walk through reset, Zicsr ops, interrupts, trap/mret and counter
// carry, followed by a randomized run. A behavioural model of the CSR file
// (plain values and 64-bit counters) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_csr_unit;

  localparam logic [31:0] TB_MTVEC_RST = 32'h0000_0080;
  localparam logic [31:0] MISA_VAL     = 32'h4000_1104;

  logic        clk;
  logic        rst_n;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_idx;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instr_ret;
  logic        trap;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret;
  logic        irq_ext, irq_tmr, irq_sw;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic [31:0] trap_vec;
  logic [31:0] mepc;

  csr_unit #(
    .XLEN        (32),
    .MTVEC_RST   (TB_MTVEC_RST),
    .VECTORED_EN (1'b1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .csr_en_i      (csr_en),
    .csr_op_i      (csr_op),
    .csr_idx_i     (csr_idx),
    .csr_wdata_i   (csr_wdata),
    .csr_rdata_o   (csr_rdata),
    .csr_illegal_o (csr_illegal),
    .instr_ret_i   (instr_ret),
    .trap_i        (trap),
    .trap_cause_i  (trap_cause),
    .trap_pc_i     (trap_pc),
    .trap_val_i    (trap_val),
    .mret_i        (mret),
    .irq_ext_i     (irq_ext),
    .irq_tmr_i     (irq_tmr),
    .irq_sw_i      (irq_sw),
    .irq_req_o     (irq_req),
    .irq_cause_o   (irq_cause),
    .trap_vec_o    (trap_vec),
    .mepc_o        (mepc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic        m_gie, m_mpie;     // mstatus.MIE / MPIE
  logic [31:0] m_ie;              // mie register value
  logic [2:0]  m_irq;             // {ext, tmr, sw} as seen last edge
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;
  bit          model_valid = 1'b0;

  typedef struct packed {
    logic        ok;
    logic        ro;
    logic [31:0] val;
  } rd_t;

  function automatic rd_t model_read(input logic [11:0] a);
    rd_t r;
    r.ok  = 1'b1;
    r.ro  = 1'b0;
    r.val = 32'h0;
    case (a)
      12'h300: r.val = 32'h1800 + 32'(m_mpie) * 128 + 32'(m_gie) * 8;
      12'h301: begin r.val = MISA_VAL; r.ro = 1'b1; end
      12'h304: r.val = m_ie;
      12'h305: r.val = m_mtvec;
      12'h340: r.val = m_mscratch;
      12'h341: r.val = m_mepc;
      12'h342: r.val = m_mcause;
      12'h343: r.val = m_mtval;
      12'h344: r.val = 32'(m_irq[2]) * 2048 + 32'(m_irq[1]) * 128 + 32'(m_irq[0]) * 8;
      12'hB00: r.val = m_cycle[31:0];
      12'hB80: r.val = m_cycle[63:32];
      12'hB02: r.val = m_instret[31:0];
      12'hB82: r.val = m_instret[63:32];
      12'hF14: r.ro = 1'b1;
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

  // One clock cycle: check all outputs against the model for the current
  // inputs, then advance the model by the same edge the DUT sees.
  task automatic tick();
    rd_t         r;
    bit          wr_try, protect;
    logic [31:0] nv, pend, base, exp_cause;
    logic        n_gie, n_mpie;
    logic [31:0] n_ie, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval;
    logic [2:0]  n_irq;
    logic [63:0] n_cycle, n_instret;
    bit          exp_req;

    #1;
    r = model_read(csr_idx);
    wr_try = csr_en && (csr_op == 2'b01 || (csr_op[1] && csr_wdata != 0));

    if (model_valid) begin
      check("rdata", csr_rdata, (csr_en && r.ok) ? r.val : 32'h0);
      check("illegal", 32'(csr_illegal), 32'(csr_en && (!r.ok || (wr_try && r.ro))));
      pend    = m_ie & 32'h888 &
                (32'(m_irq[2]) * 2048 + 32'(m_irq[1]) * 128 + 32'(m_irq[0]) * 8);
      exp_req = rst_n && m_gie && pend != 0;
      if (!exp_req)      exp_cause = 32'h0;
      else if (pend[11]) exp_cause = 32'h8000_000B;
      else if (pend[3])  exp_cause = 32'h8000_0003;
      else               exp_cause = 32'h8000_0007;
      check("irq_req", 32'(irq_req), 32'(exp_req));
      check("irq_cause", irq_cause, exp_cause);
      base = m_mtvec & ~32'h3;
      check("trap_vec", trap_vec,
            (m_mtvec[0] && trap_cause[31]) ? base + 4 * 32'(trap_cause[4:0]) : base);
      check("mepc_o", mepc, rst_n ? m_mepc : 32'h0);
    end

    n_gie = m_gie; n_mpie = m_mpie; n_ie = m_ie; n_irq = m_irq;
    n_mtvec = m_mtvec; n_mscratch = m_mscratch; n_mepc = m_mepc;
    n_mcause = m_mcause; n_mtval = m_mtval;
    n_cycle = m_cycle; n_instret = m_instret;

    if (!rst_n) begin
      n_gie = 0; n_mpie = 0; n_ie = 0; n_irq = 0;
      n_mtvec = TB_MTVEC_RST; n_mscratch = 0; n_mepc = 0;
      n_mcause = 0; n_mtval = 0; n_cycle = 0; n_instret = 0;
    end else begin
      n_cycle = m_cycle + 1;
      if (instr_ret) n_instret = m_instret + 1;
      if (r.ok && !r.ro && wr_try) begin
        case (csr_op)
          2'b10:   nv = r.val | csr_wdata;
          2'b11:   nv = r.val & ~csr_wdata;
          default: nv = csr_wdata;
        endcase
        protect = trap || mret;
        case (csr_idx)
          12'h300: if (!protect) begin n_gie = nv[3]; n_mpie = nv[7]; end
          12'h304: n_ie = nv & 32'h888;
          12'h305: n_mtvec = nv & ~32'h2;
          12'h340: n_mscratch = nv;
          12'h341: if (!protect) n_mepc = nv & ~32'h1;
          12'h342: if (!protect) n_mcause = nv;
          12'h343: if (!protect) n_mtval = nv;
          12'hB00: n_cycle = {m_cycle[63:32], nv};
          12'hB80: n_cycle = {nv, m_cycle[31:0]};
          12'hB02: n_instret = {m_instret[63:32], nv};
          12'hB82: n_instret = {nv, m_instret[31:0]};
          default: ;
        endcase
      end
      if (trap) begin
        n_mepc = trap_pc & ~32'h1; n_mcause = trap_cause; n_mtval = trap_val;
        n_mpie = m_gie; n_gie = 1'b0;
      end else if (mret) begin
        n_gie = m_mpie; n_mpie = 1'b1;
      end
      n_irq = {irq_ext, irq_tmr, irq_sw};
    end

    @(posedge clk);
    m_gie = n_gie; m_mpie = n_mpie; m_ie = n_ie; m_irq = n_irq;
    m_mtvec = n_mtvec; m_mscratch = n_mscratch; m_mepc = n_mepc;
    m_mcause = n_mcause; m_mtval = n_mtval;
    m_cycle = n_cycle; m_instret = n_instret;
    model_valid = 1'b1;
    #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] idx, input logic [31:0] wd);
    csr_en = 1'b1; csr_op = op; csr_idx = idx; csr_wdata = wd;
  endtask

  task automatic idle();
    csr_en = 1'b0; csr_op = 2'b00; csr_idx = 12'h000; csr_wdata = 32'h0;
  endtask

  logic [11:0] addrs [14] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                              12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                              12'hB80, 12'hB02, 12'hB82, 12'hF14};

  initial begin
    rst_n = 1'b0; idle();
    instr_ret = 0; trap = 0; mret = 0; trap_cause = 0; trap_pc = 0; trap_val = 0;
    irq_ext = 0; irq_tmr = 0; irq_sw = 0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset values; mcycle counts edges since reset release.
    csr(2'b00, 12'h305, 0); #1 check("rst_mtvec", csr_rdata, TB_MTVEC_RST); tick();
    csr(2'b00, 12'h300, 0); #1 check("rst_mstatus", csr_rdata, 32'h0000_1800); tick();
    csr(2'b00, 12'h301, 0); #1 check("rst_misa", csr_rdata, MISA_VAL); tick();
    csr(2'b00, 12'hB00, 0); #1 check("mcycle_n", csr_rdata, 32'd3); tick();
    csr(2'b00, 12'h7C0, 0); #1 check("unimpl_ill", 32'(csr_illegal), 32'd1);
    check("unimpl_rd", csr_rdata, 32'h0); tick();

    // Read-modify-write ops.
    csr(2'b01, 12'h340, 32'hA5A5_A5A5); tick();
    csr(2'b10, 12'h340, 32'h0000_00F0); tick();
    csr(2'b11, 12'h340, 32'h0000_0005); #1 check("rs_result", csr_rdata, 32'hA5A5_A5F5); tick();
    csr(2'b00, 12'h340, 0); #1 check("rc_result", csr_rdata, 32'hA5A5_A5F0); tick();
    csr(2'b01, 12'h301, 32'h1234_5678); #1 check("rw_misa_ill", 32'(csr_illegal), 32'd1); tick();
    csr(2'b10, 12'h301, 32'h0); #1 check("rs0_misa_ok", 32'(csr_illegal), 32'd0);
    check("misa_kept", csr_rdata, MISA_VAL); tick();
    csr(2'b01, 12'h341, 32'h0000_1235); tick();
    csr(2'b00, 12'h341, 0); #1 check("mepc_bit0", csr_rdata, 32'h0000_1234); tick();

    // Interrupt request and priority.
    csr(2'b01, 12'h304, 32'h0000_0888); tick();
    csr(2'b10, 12'h300, 32'h0000_0008); tick();
    idle(); irq_tmr = 1; irq_ext = 1; tick();
    #1 check("irq_req_on", 32'(irq_req), 32'd1);
    check("irq_cause_mei", irq_cause, 32'h8000_000B);
    irq_ext = 0; tick();
    #1 check("irq_cause_mti", irq_cause, 32'h8000_0007);
    csr(2'b11, 12'h300, 32'h0000_0008); tick();
    #1 check("irq_req_off", 32'(irq_req), 32'd0);
    idle(); irq_tmr = 0; tick();

    // Trap entry and mret.
    csr(2'b01, 12'h305, 32'h0000_1001); tick();
    csr(2'b10, 12'h300, 32'h0000_0008); tick();
    idle(); trap = 1; trap_pc = 32'h0000_0103; trap_cause = 32'h8000_0007; trap_val = 32'h55;
    #1 check("vec_target", trap_vec, 32'h0000_101C); tick();
    trap = 0; csr(2'b00, 12'h300, 0);
    #1 check("trap_mepc", mepc, 32'h0000_0102);
    check("trap_mstatus", csr_rdata, 32'h0000_1880); tick();
    idle(); mret = 1; tick();
    mret = 0; csr(2'b00, 12'h300, 0);
    #1 check("mret_mstatus", csr_rdata, 32'h0000_1888); tick();

    // Counter carry and minstret hold.
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    csr(2'b01, 12'hB80, 32'h0); tick();
    csr(2'b00, 12'hB00, 0); #1 check("mcycle_ff", csr_rdata, 32'hFFFF_FFFF); tick();
    csr(2'b00, 12'hB00, 0); #1 check("mcycle_wrap", csr_rdata, 32'h0); tick();
    csr(2'b00, 12'hB80, 0); #1 check("mcycleh_carry", csr_rdata, 32'h1); tick();
    csr(2'b00, 12'hB02, 0); #1 check("minstret_hold", csr_rdata, 32'h0); tick();

    // Trap beats a same-cycle CSR write to mepc; mscratch still commits.
    trap = 1; trap_pc = 32'h0000_2000; trap_cause = 32'h2; trap_val = 32'hDEAD;
    csr(2'b01, 12'h341, 32'h0000_1234); tick();
    trap = 0; csr(2'b00, 12'h341, 0); #1 check("trap_wins_mepc", csr_rdata, 32'h0000_2000); tick();
    trap = 1; csr(2'b01, 12'h340, 32'h0000_5555); tick();
    trap = 0; csr(2'b00, 12'h340, 0); #1 check("mscratch_commit", csr_rdata, 32'h0000_5555); tick();

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      sel       = $urandom_range(0, 15);
      csr_en    = ($urandom_range(0, 3) != 0);
      csr_op    = 2'($urandom_range(0, 3));
      csr_idx   = (sel < 14) ? addrs[sel] : 12'($urandom);
      csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      instr_ret = 1'($urandom_range(0, 1));
      trap      = ($urandom_range(0, 15) == 0);
      mret      = ($urandom_range(0, 15) == 0);
      trap_cause = $urandom; trap_pc = $urandom; trap_val = $urandom;
      irq_ext   = 1'($urandom_range(0, 1));
      irq_tmr   = 1'($urandom_range(0, 1));
      irq_sw    = 1'($urandom_range(0, 1));
      tick();
    end

    // Reset arriving together with a trap discards the trap.
    idle(); instr_ret = 0; mret = 0; irq_ext = 0; irq_tmr = 0; irq_sw = 0;
    rst_n = 1'b0; trap = 1; trap_pc = 32'h0000_0ABC; trap_cause = 32'h5;
    tick();
    rst_n = 1'b1; trap = 0;
    csr(2'b00, 12'h341, 0); #1 check("rst_trap_mepc", csr_rdata, 32'h0); tick();
    csr(2'b00, 12'h342, 0); #1 check("rst_trap_mcause", csr_rdata, 32'h0); tick();
    idle(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised machine-mode CSR unit, successor to the core's fixed CSR register file.
- Adds Zicsr read-modify-write ops (RW/RS/RC), free-running 64-bit mcycle/minstret, hardware trap entry and mret sequencing, interrupt pending/enable logic with prioritised request, and illegal-access detection.
- Sits beside the execute/writeback stage.
- Exports the trap vector and return PC to fetch.

Parameters:
- XLEN, 32: data width; only 32 supported, counters split into low/high halves.
- MTVEC_RST, 32'h0000_0000: reset value of mtvec.
- VECTORED_EN, 1: 1 = mtvec.MODE=1 permitted (vectored interrupts); 0 = MODE forced to 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active low
- csr_en_i  in  1  CSR instruction valid this cycle
- csr_op_i  in  2  00 none, 01 RW, 10 RS, 11 RC
- csr_idx_i  in  12  CSR address
- csr_wdata_i  in  XLEN  rs1 value or zimm
- csr_rdata_o  out  XLEN  old CSR value (combinational)
- csr_illegal_o  out  1  unimplemented address, or write to read-only CSR
- instr_ret_i  in  1  one instruction retired this cycle
- trap_i  in  1  take trap this cycle
- trap_cause_i  in  XLEN  mcause value (bit31 = interrupt)
- trap_pc_i  in  XLEN  PC to save in mepc
- trap_val_i  in  XLEN  mtval value
- mret_i  in  1  mret retiring
- irq_ext_i / irq_tmr_i / irq_sw_i  in  1 each  level interrupt lines
- irq_req_o  out  1  interrupt should be taken
- irq_cause_o  out  XLEN  cause for pending interrupt
- trap_vec_o  out  XLEN  trap target PC
- mepc_o  out  XLEN  return PC for mret

Behaviour:
- Implemented CSRs:
  - mstatus 300: MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11.
  - misa 301: RO, 32'h4000_1104 (RV32IMC).
  - mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343.
  - mip 344: bits 3/7/11 RO, reflect irq inputs registered 1 cycle.
  - mcycle B00 / mcycleh B80, minstret B02 / minstreth B82.
  - mhartid F14: RO, 0.
- Any other address with csr_en_i: csr_illegal_o=1, rdata 0, no state change.
- Reads: combinational; csr_rdata_o = current value whenever csr_en_i, else 0.
- Writes: new = RW wdata; RS old|wdata; RC old&~wdata.
  - RS/RC with wdata==0: no write and no illegal flag, even for RO CSRs.
  - RW to a RO CSR, or RS/RC with nonzero wdata to a RO CSR: illegal, no write.
  - Write takes effect at next posedge.
- WARL masks:
  - mstatus writes only bits 3 and 7.
  - mie writes only bits 3, 7, 11.
  - mepc bit0 forced 0.
  - mtvec bit1 forced 0; bit0 forced 0 if VECTORED_EN=0.
- Counters:
  - mcycle 64-bit, increments every cycle out of reset.
  - minstret increments when instr_ret_i; carry from low into high half.
  - Software write to either half in the same cycle overrides the increment for the whole 64-bit counter that cycle.
  - Wrap: FFFF_FFFF_FFFF_FFFF -> 0.
- Trap entry (trap_i), applied at posedge:
  - mepc<=trap_pc_i&~1, mcause<=trap_cause_i, mtval<=trap_val_i.
  - MPIE<=MIE, MIE<=0.
- mret_i: MIE<=MPIE, MPIE<=1.
- Priority, same cycle: trap_i > mret_i > CSR write. A CSR write coinciding with trap_i or mret_i is dropped for mstatus/mepc/mcause/mtval; writes to other CSRs still commit.
- Interrupts:
  - pend = mip & mie.
  - irq_req_o = MIE & |pend[11,7,3].
  - Priority MEI(11) > MSI(3) > MTI(7).
  - irq_cause_o = {1'b1, 27'b0, code}; 0 when irq_req_o=0.
- trap_vec_o:
  - mtvec.MODE=1 and trap_cause_i[31]=1: {BASE,2'b00} + 4*cause[4:0].
  - Otherwise {BASE,2'b00}.
  - Combinational from trap_cause_i.
- mepc_o = mepc register.
- Reset (rst_ni=0 at posedge):
  - All CSRs 0 except mtvec=MTVEC_RST and MPP=11; counters 0.
  - Outputs while in reset: irq_req_o=0, irq_cause_o=0, csr_illegal_o per combinational decode, mepc_o=0.
  - Reset asserted mid-trap discards the trap.

Test Plan:
- Reset, then read mtvec/mstatus/misa -> MTVEC_RST / 32'h0000_1800 / 32'h4000_1104; mcycle=N after N cycles.
- RW mscratch=A5A5_A5A5; RS 0000_00F0; RC 0000_0005 -> reads A5A5_A5F5, then A5A5_A5F0; RW misa -> csr_illegal_o=1, value unchanged; RS misa with 0 -> no illegal.
- Set mie=0x888, MIE=1, assert irq_tmr_i and irq_ext_i -> one cycle later irq_req_o=1, irq_cause_o=8000_000B; drop ext -> 8000_0007; MIE=0 -> irq_req_o=0.
- trap_i with pc=0000_0103, cause=8000_0007, mtvec=0000_1001 -> trap_vec_o=0000_101C; next cycle mepc=0000_0102, MIE=0, MPIE=1; mret -> MIE=1, MPIE=1.
- Write mcycle=FFFF_FFFF, mcycleh=0 -> next cycle mcycleh=1, mcycle=0; minstret holds without instr_ret_i.
- Same-cycle trap_i and RW mepc=1234 -> mepc=trap_pc_i; same-cycle RW mscratch commits.
